// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : sequential ALU with shift-add multiplier, valid/ready handshake
//           and an architectural {N,Z,C,V} status register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       res_flags,
  output logic [3:0]       status
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       status_q, status_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             retire;
  logic             accept;
  logic             cur_c;
  logic             cur_v;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    flags_d  = flags_q;
    s_d      = s_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_next = acc_q;

    retire   = (state_q == ST_DONE) && out_ready;
    in_ready = (state_q == ST_IDLE) || retire;
    accept   = in_valid && in_ready;

    // A retiring result that updates status is forwarded to the op accepted on the same edge
    status_d = (retire && s_q) ? flags_q : status_q;
    cur_c    = status_d[1];
    cur_v    = status_d[0];

    sum_ext = '0;
    op_res  = '0;
    op_c    = cur_c;
    op_v    = cur_v;
    case (exe_cmd)
      OP_MOV: op_res = val2;
      OP_MVN: op_res = ~val2;
      OP_ADD, OP_ADC: begin
        sum_ext = {1'b0, val1} + {1'b0, val2}
                + {{WIDTH{1'b0}}, (exe_cmd == OP_ADC) ? cur_c : 1'b0};
        op_res  = sum_ext[WIDTH-1:0];
        op_c    = sum_ext[WIDTH];
        op_v    = (val1[WIDTH-1] == val2[WIDTH-1]) && (op_res[WIDTH-1] != val1[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        sum_ext = {1'b0, val1} + {1'b0, ~val2}
                + {{WIDTH{1'b0}}, (exe_cmd == OP_SBC) ? cur_c : 1'b1};
        op_res  = sum_ext[WIDTH-1:0];
        op_c    = sum_ext[WIDTH];
        op_v    = (val1[WIDTH-1] != val2[WIDTH-1]) && (op_res[WIDTH-1] != val1[WIDTH-1]);
      end
      OP_AND: op_res = val1 & val2;
      OP_ORR: op_res = val1 | val2;
      OP_EOR: op_res = val1 ^ val2;
      default: op_res = '0;
    endcase

    if (retire) begin
      state_d = ST_IDLE;
    end

    if (accept) begin
      s_d = s_bit;
      if (exe_cmd == OP_MUL) begin
        state_d  = ST_BUSY;
        mcand_d  = val1;
        mplier_d = val2;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = ST_DONE;
        res_d   = op_res;
        flags_d = {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
      end
    end

    // One multiplier bit per cycle; status cannot change while busy
    if (state_q == ST_BUSY) begin
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = ST_DONE;
        res_d   = acc_next;
        flags_d = {acc_next[WIDTH-1], (acc_next == '0), status_q[1], status_q[0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      flags_q  <= '0;
      status_q <= '0;
      s_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      status_q <= status_d;
      s_q      <= s_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign alu_res   = res_q;
  assign res_flags = flags_q;
  assign status    = status_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : directed table-driven bench for seq_alu plus handshake,
//              multiply, forwarding and reset corner sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_res;
  logic [3:0]  res_flags;
  logic [3:0]  status;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs [18];

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exe_cmd   (exe_cmd),
    .s_bit     (s_bit),
    .val1      (val1),
    .val2      (val2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_res   (alu_res),
    .res_flags (res_flags),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    chk($sformatf("v%0d_in_ready", idx), {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    exe_cmd   = v.cmd;
    s_bit     = v.s;
    val1      = v.a;
    val2      = v.b;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    exe_cmd  = 4'b0010;
    val1     = 32'hDEADBEEF;
    val2     = 32'h0BADF00D;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), (v.cmd == 4'b1010) ? 32'd32 : 32'd0);
    chk($sformatf("v%0d_res", idx), alu_res, v.res);
    chk($sformatf("v%0d_flags", idx), {28'b0, res_flags}, {28'b0, v.flags});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("v%0d_retired", idx), {31'b0, out_valid}, 32'd0);
    chk($sformatf("v%0d_status", idx), {28'b0, status}, {28'b0, v.st});
  endtask

  initial begin
    int  n;
    bit  bad_ready;
    bit  seen;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    exe_cmd   = 4'b0000;
    s_bit     = 1'b0;
    val1      = 32'h0;
    val2      = 32'h0;
    out_ready = 1'b0;

    //          cmd      s     val1          val2          res           flags    status
    vecs[0]  = '{4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 4'b0110};
    vecs[1]  = '{4'b0100, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1000, 4'b1000};
    vecs[2]  = '{4'b0100, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 4'b0011};
    vecs[3]  = '{4'b0011, 1'b0, 32'h00000001, 32'h00000002, 32'h00000004, 4'b0000, 4'b0011};
    vecs[4]  = '{4'b0001, 1'b0, 32'h12345678, 32'h80000000, 32'h80000000, 4'b1011, 4'b0011};
    vecs[5]  = '{4'b1001, 1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b1011, 4'b1011};
    vecs[6]  = '{4'b0110, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0011, 4'b0011};
    vecs[7]  = '{4'b1000, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0111, 4'b0111};
    vecs[8]  = '{4'b0101, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000007, 4'b0010, 4'b0010};
    vecs[9]  = '{4'b0010, 1'b1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0101, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000006, 4'b0010, 4'b0010};
    vecs[11] = '{4'b0000, 1'b1, 32'h11111111, 32'h22222222, 32'h00000000, 4'b0110, 4'b0110};
    vecs[12] = '{4'b0011, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 4'b1001, 4'b1001};
    vecs[13] = '{4'b0111, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0001, 4'b1001};
    vecs[14] = '{4'b1111, 1'b0, 32'h55555555, 32'h33333333, 32'h00000000, 4'b0101, 4'b1001};
    vecs[15] = '{4'b1010, 1'b0, 32'h00001234, 32'h00005678, 32'h06260060, 4'b0001, 4'b1001};
    vecs[16] = '{4'b1010, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0001, 4'b0001};
    vecs[17] = '{4'b1011, 1'b0, 32'h00000009, 32'h00000009, 32'h00000000, 4'b0101, 4'b0001};

    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_res", alu_res, 32'd0);
    chk("rst_res_flags", {28'b0, res_flags}, 32'd0);
    chk("rst_status", {28'b0, status}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_vec(i, vecs[i]);
    end

    // Carry forwarded from a retiring ADD into an ADC accepted on the same edge
    in_valid = 1'b1; exe_cmd = 4'b0010; s_bit = 1'b1;
    val1 = 32'hFFFFFFFF; val2 = 32'h00000002; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("fwd_add_valid", {31'b0, out_valid}, 32'd1);
    chk("fwd_add_res", alu_res, 32'h00000001);
    chk("fwd_add_flags", {28'b0, res_flags}, {28'b0, 4'b0010});
    out_ready = 1'b1;
    in_valid = 1'b1; exe_cmd = 4'b0011; s_bit = 1'b0;
    val1 = 32'h00000002; val2 = 32'h00000003;
    #1;
    chk("fwd_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fwd_adc_valid", {31'b0, out_valid}, 32'd1);
    chk("fwd_adc_res", alu_res, 32'h00000006);
    chk("fwd_adc_flags", {28'b0, res_flags}, {28'b0, 4'b0000});
    chk("fwd_status_mid", {28'b0, status}, {28'b0, 4'b0010});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fwd_retired", {31'b0, out_valid}, 32'd0);
    chk("fwd_status_end", {28'b0, status}, {28'b0, 4'b0010});

    // MUL with zero low result; requests offered while busy must be ignored
    in_valid = 1'b1; exe_cmd = 4'b1010; s_bit = 1'b1;
    val1 = 32'h00010000; val2 = 32'h00010000; out_ready = 1'b0;
    tick();
    exe_cmd = 4'b0010; val1 = 32'h00000011; val2 = 32'h00000022; out_ready = 1'b1;
    n = 0;
    bad_ready = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad_ready = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mul_latency", 32'(n + 1), 32'd33);
    chk("mul_busy_ready", {31'b0, bad_ready}, 32'd0);
    chk("mul_res", alu_res, 32'h00000000);
    chk("mul_flags", {28'b0, res_flags}, {28'b0, 4'b0110});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mul_retired", {31'b0, out_valid}, 32'd0);
    chk("mul_status", {28'b0, status}, {28'b0, 4'b0110});

    // Backpressure: result held while out_ready is low
    in_valid = 1'b1; exe_cmd = 4'b0111; s_bit = 1'b1;
    val1 = 32'h000000F0; val2 = 32'h0000000F;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      val1 = 32'(k * 7 + 1); val2 = 32'hFFFF0000;
      chk($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_res", k), alu_res, 32'h000000FF);
      chk($sformatf("bp%0d_flags", k), {28'b0, res_flags}, {28'b0, 4'b0010});
      chk($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      if (k < 2) tick();
    end
    chk("bp_status_hold", {28'b0, status}, {28'b0, 4'b0110});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_retired", {31'b0, out_valid}, 32'd0);
    chk("bp_status", {28'b0, status}, {28'b0, 4'b0010});
    tick();
    chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a multiply discards it
    in_valid = 1'b1; exe_cmd = 4'b1010; s_bit = 1'b1;
    val1 = 32'h00000003; val2 = 32'h00000005;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_alu_res", alu_res, 32'd0);
    chk("mrst_res_flags", {28'b0, res_flags}, 32'd0);
    chk("mrst_status", {28'b0, status}, 32'd0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("mrst_no_result", {31'b0, seen}, 32'd0);
    chk("mrst_status_end", {28'b0, status}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001: Parameter WIDTH, default 32: datapath width in bits, at least 4.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004: in_valid  input  1  operation request valid.
REQ-005: in_ready  output  1  block can accept an operation this cycle.
REQ-006: exe_cmd  input  4  opcode: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL; any other code is NOP.
REQ-007: s_bit  input  1  update status flags when this operation's result is consumed.
REQ-008: val1, val2  input  WIDTH each  operands; val2 is the only operand for MOV/MVN.
REQ-009: out_valid  output  1  result valid.
REQ-010: out_ready  input  1  downstream accepts result.
REQ-011: alu_res  output  WIDTH  registered result.
REQ-012: res_flags  output  4  {N,Z,C,V} computed for alu_res.
REQ-013: status  output  4  architectural {N,Z,C,V} status register.

Function
REQ-014: Accept occurs on in_valid && in_ready; operands, exe_cmd and s_bit are captured at accept; inputs are ignored at all other times.
REQ-015: FSM states IDLE, BUSY, DONE; in_ready = (IDLE) || (DONE && out_ready); out_valid = (DONE).
REQ-016: Non-MUL op accepted in cycle n: IDLE/DONE -> DONE, out_valid and alu_res valid in cycle n+1.
REQ-017: MUL accepted in cycle n: -> BUSY, shift-add one multiplier bit per cycle for WIDTH cycles, -> DONE; out_valid in cycle n+WIDTH+1; alu_res = low WIDTH bits of val1*val2 (unsigned).
REQ-018: In DONE, alu_res and res_flags are held stable until out_ready; DONE && out_ready without a new accept -> IDLE.
REQ-019: DONE && out_ready with a simultaneous accept retires the old result and starts the new op in the same edge (no bubble).
REQ-020: ADD/ADC: WIDTH+1-bit unsigned sum; C = carry-out; V = operands same sign and result sign differs; ADC adds carry-in.
REQ-021: SUB/SBC: val1 - val2 (SBC also subtracts NOT carry-in); C = 1 when no borrow (unsigned val1 >= subtrahend); V = operand signs differ and result sign differs from val1.
REQ-022: MOV, MVN, AND, ORR, EOR, MUL: C and V in res_flags equal the current status C and V (unchanged); N and Z computed from alu_res.
REQ-023: NOP: alu_res = 0, Z = 1, N = 0, C/V unchanged; 1-cycle latency like other single-cycle ops.
REQ-024: N = alu_res[WIDTH-1]; Z = (alu_res == 0) for all ops.
REQ-025: status loads res_flags on the retire edge (out_valid && out_ready) iff captured s_bit = 1; otherwise it holds.
REQ-026: Carry-in for ADC/SBC is status C at accept; when an accept coincides with a retire that updates status, the retiring res_flags C is forwarded.
REQ-027: No operation may be dropped or duplicated under any out_ready pattern.

Reset
REQ-028: rst_n = 0 at a rising edge forces IDLE, out_valid = 0, alu_res = 0, res_flags = 0, status = 0; in_ready = 1 from the next cycle.
REQ-029: Reset during BUSY or DONE discards the pending operation with no status update.

Verification
REQ-030: ADD, s_bit=1, 0xFFFFFFFF + 0x00000001 -> alu_res 0x00000000, res_flags/status N0 Z1 C1 V0, out_valid one cycle after accept.
REQ-031: SUB, s_bit=1, 5 - 7 -> 0xFFFFFFFE, N1 Z0 C0 V0; SUB 0x80000000 - 1 -> 0x7FFFFFFF, N0 Z0 C1 V1.
REQ-032: ADD s_bit=1 0xFFFFFFFF+2 (C=1), then ADC 2+3 accepted on the retire cycle with out_ready=1 -> 0x00000006 (forwarded carry).
REQ-033: MUL 0x00010000 * 0x00010000, s_bit=1 -> alu_res 0, Z1, C/V unchanged; out_valid exactly 33 cycles after accept; in_ready low throughout BUSY.
REQ-034: ORR 0xF0 | 0x0F with out_ready low 3 cycles -> alu_res 0x000000FF held stable, in_ready 0, single retire when out_ready rises.
REQ-035: Reset pulse mid-MUL -> next cycle out_valid 0, alu_res 0, status 0, in_ready 1; no result emitted.
